// File: rtl/axi_ad7124_drdy_detect.sv
// Multi-channel glitch-filtered AD7124 DOUT/RDY falling-edge detector in the spi_clk domain.
// Define AD7124_DRDY_TIMEOUT_EN to build the missed-conversion watchdog; otherwise timeout is tied 0.
module axi_ad7124_drdy_detect #(
  parameter int NUM_CH     = 1,
  parameter int FILTER_LEN = 1,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                 spi_clk,
  input  logic                 spi_resetn,
  input  logic [NUM_CH-1:0]    spi_sdi,
  input  logic [NUM_CH-1:0]    spi_cs,
  input  logic                 spi_active,
  input  logic [NUM_CH-1:0]    enable,
  input  logic [NUM_CH-1:0]    trigger_ack,
  input  logic [NUM_CH-1:0]    overrun_clr,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 timeout_clr,
  output logic [NUM_CH-1:0]    trigger,
  output logic                 trigger_any,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    overrun,
  output logic                 timeout
);

  typedef enum logic [1:0] {DISARMED, ARMED, LOW, DONE} state_t;

  localparam logic [7:0] FL    = 8'(FILTER_LEN);
  localparam logic [7:0] FL_M1 = FL - 8'd1;

  (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sdi_d1;
  (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sdi_d2;

  logic [NUM_CH-1:0] qual;
  logic [NUM_CH-1:0] fire;
  logic              unused_ok;

  // Synchroniser: detection taps the first stage, second stage only settles metastability
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      sdi_d1 <= '1;
      sdi_d2 <= '1;
    end else begin
      sdi_d1 <= spi_sdi;
      sdi_d2 <= sdi_d1;
    end
  end

  assign qual = enable & ~spi_cs & {NUM_CH{~spi_active}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t     state;
    logic [7:0] cnt;

    assign fire[i] = qual[i] & ~sdi_d1[i] &
                     (((state == ARMED) & (FL == 8'd1)) | ((state == LOW) & (cnt == FL_M1)));

    // Arm after FILTER_LEN highs, fire after FILTER_LEN lows; losing qualification always disarms
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
      if (!spi_resetn) begin
        state <= DISARMED;
        cnt   <= 8'd0;
      end else if (!qual[i]) begin
        state <= DISARMED;
        cnt   <= 8'd0;
      end else begin
        case (state)
          DISARMED, DONE: begin
            if (!sdi_d1[i]) begin
              cnt <= 8'd0;
            end else if (cnt == FL_M1) begin
              state <= ARMED;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ARMED: begin
            if (!sdi_d1[i]) begin
              if (FL == 8'd1) begin
                state <= DONE;
                cnt   <= 8'd0;
              end else begin
                state <= LOW;
                cnt   <= 8'd1;
              end
            end
          end
          LOW: begin
            if (sdi_d1[i]) begin
              state <= ARMED;
              cnt   <= 8'd0;
            end else if (cnt == FL_M1) begin
              state <= DONE;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            state <= DISARMED;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

  // Trigger pulse and acknowledge bookkeeping; set beats clear on both pending and overrun
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      trigger     <= '0;
      trigger_any <= 1'b0;
      pending     <= '0;
      overrun     <= '0;
    end else begin
      trigger     <= fire;
      trigger_any <= |trigger;
      pending     <= fire | (pending & ~trigger_ack);
      overrun     <= (fire & pending & ~trigger_ack) | (overrun & ~overrun_clr);
    end
  end

`ifdef AD7124_DRDY_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 to_run;
  logic                 to_expire;

  assign to_run    = (|enable) && (timeout_limit != '0);
  assign to_expire = to_run && !(|fire) && (to_cnt == timeout_limit);

  // Watchdog restarts on any fire; expiry wins over a simultaneous clear
  always_ff @(posedge spi_clk or negedge spi_resetn) begin
    if (!spi_resetn) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!to_run || (|fire) || to_expire) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;
      if (to_expire)        timeout <= 1'b1;
      else if (timeout_clr) timeout <= 1'b0;
    end
  end

  assign unused_ok = ^sdi_d2;
`else
  assign timeout   = 1'b0;
  assign unused_ok = ^{sdi_d2, timeout_limit, timeout_clr};
`endif

endmodule

// File: tb/tb_axi_ad7124_drdy_detect.sv
// Bench for axi_ad7124_drdy_detect: a 4-channel FILTER_LEN=4 instance and a 1-channel FILTER_LEN=1
// instance share stimulus and are checked every cycle against a sample-history reference model.
module tb_axi_ad7124_drdy_detect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sdi = 4'hF, cs = 4'h0, en = 4'h0, ack = 4'h0, oclr = 4'h0;
  logic        active = 1'b0, tclr = 1'b0;
  logic [23:0] limit = 24'd0;

  logic [3:0]  trig_a, pend_a, ovr_a;
  logic        any_a, to_a;
  logic        trig_b, pend_b, ovr_b, any_b, to_b;

  always #5 clk = ~clk;

  axi_ad7124_drdy_detect #(.NUM_CH(4), .FILTER_LEN(4), .TIMEOUT_W(24)) dut_a (
    .spi_clk(clk), .spi_resetn(rst_n), .spi_sdi(sdi), .spi_cs(cs), .spi_active(active),
    .enable(en), .trigger_ack(ack), .overrun_clr(oclr), .timeout_limit(limit),
    .timeout_clr(tclr), .trigger(trig_a), .trigger_any(any_a), .pending(pend_a),
    .overrun(ovr_a), .timeout(to_a));

  axi_ad7124_drdy_detect #(.NUM_CH(1), .FILTER_LEN(1), .TIMEOUT_W(24)) dut_b (
    .spi_clk(clk), .spi_resetn(rst_n), .spi_sdi(sdi[0]), .spi_cs(cs[0]), .spi_active(active),
    .enable(en[0]), .trigger_ack(ack[0]), .overrun_clr(oclr[0]), .timeout_limit(limit),
    .timeout_clr(tclr), .trigger(trig_b), .trigger_any(any_b), .pending(pend_b),
    .overrun(ovr_b), .timeout(to_b));

  // Model: per monitored line (0..3 = dut_a channels, 4 = dut_b) a history of what each edge saw
  bit hq[5][$];  // qualified at that edge
  bit hh[5][$];  // synchronised level seen at that edge
  bit hf[5][$];  // fired at that edge
  bit d1m[5];
  bit e_trig[5], e_pend[5], e_ovr[5];
  bit e_any_a, e_any_b, e_to_a, e_to_b;
  int tc_a, tc_b;
  int errors = 0, checks = 0, cyc = 0;

  // Fire at the newest edge t iff edges t-FL+1..t are qualified lows with no fire among them, and
  // before them, since the last unqualified edge or fire, there is a run of FL qualified highs.
  function automatic bit fire_at(int k, int fl);
    int t = hq[k].size() - 1;
    int run = 0;
    if (t - fl + 1 < 0) return 1'b0;
    for (int j = t - fl + 1; j <= t; j++)
      if (!hq[k][j] || hh[k][j] || (j < t && hf[k][j])) return 1'b0;
    for (int j = t - fl; j >= 0; j--) begin
      if (!hq[k][j] || hf[k][j]) return 1'b0;
      if (hh[k][j]) begin
        run++;
        if (run == fl) return 1'b1;
      end else begin
        run = 0;
      end
    end
    return 1'b0;
  endfunction

  task automatic tmodel(input bit fired, input bit anyen, inout int tc, inout bit flag);
`ifdef AD7124_DRDY_TIMEOUT_EN
    bit expire = 1'b0;
    if (!anyen || limit == 0 || fired) tc = 0;
    else if (tc == int'(limit)) begin tc = 0; expire = 1'b1; end
    else tc++;
    if (expire) flag = 1'b1;
    else if (tclr) flag = 1'b0;
`else
    tc = 0;
    flag = 1'b0;
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      hq[k].delete(); hh[k].delete(); hf[k].delete();
      d1m[k] = 1'b1; e_trig[k] = 1'b0; e_pend[k] = 1'b0; e_ovr[k] = 1'b0;
    end
    e_any_a = 1'b0; e_any_b = 1'b0; e_to_a = 1'b0; e_to_b = 1'b0; tc_a = 0; tc_b = 0;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("trig_a", trig_a, {e_trig[3], e_trig[2], e_trig[1], e_trig[0]});
    chk("pend_a", pend_a, {e_pend[3], e_pend[2], e_pend[1], e_pend[0]});
    chk("ovr_a",  ovr_a,  {e_ovr[3], e_ovr[2], e_ovr[1], e_ovr[0]});
    chk("any_a",  {3'b0, any_a}, {3'b0, e_any_a});
    chk("to_a",   {3'b0, to_a},  {3'b0, e_to_a});
    chk("trig_b", {3'b0, trig_b}, {3'b0, e_trig[4]});
    chk("pend_b", {3'b0, pend_b}, {3'b0, e_pend[4]});
    chk("ovr_b",  {3'b0, ovr_b},  {3'b0, e_ovr[4]});
    chk("any_b",  {3'b0, any_b},  {3'b0, e_any_b});
    chk("to_b",   {3'b0, to_b},   {3'b0, e_to_b});
  endtask

  // One clock: predict the edge from the current inputs, advance, then compare
  task automatic tick();
    bit f[5];
    e_any_a = e_trig[0] | e_trig[1] | e_trig[2] | e_trig[3];
    e_any_b = e_trig[4];
    for (int k = 0; k < 5; k++) begin
      int ch = (k < 4) ? k : 0;
      int fl = (k < 4) ? 4 : 1;
      hq[k].push_back(en[ch] & ~cs[ch] & ~active);
      hh[k].push_back(d1m[k]);
      hf[k].push_back(1'b0);
      f[k] = fire_at(k, fl);
      hf[k][hf[k].size() - 1] = f[k];
      d1m[k] = sdi[ch];
      e_ovr[k]  = (f[k] & e_pend[k] & ~ack[ch]) | (e_ovr[k] & ~oclr[ch]);
      e_pend[k] = f[k] | (e_pend[k] & ~ack[ch]);
      e_trig[k] = f[k];
    end
    tmodel(f[0] | f[1] | f[2] | f[3], |en, tc_a, e_to_a);
    tmodel(f[4], en[0], tc_b, e_to_b);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic hold(input logic [3:0] s, input int n);
    sdi = s;
    repeat (n) tick();
  endtask

  initial begin
    int rem[4];
    model_reset();
    repeat (3) begin @(posedge clk); #1; check_all(); end
    rst_n = 1'b1;

    // Glitch rejection and simultaneous fire on channels 0 and 2, channel 3 disabled
    en = 4'b0111;
    hold(4'hF, 10); hold(4'b0010, 2); hold(4'hF, 5); hold(4'b0010, 6); hold(4'hF, 6);

    // spi_active during the low run disarms; re-arm needs a full high run
    en = 4'hF;
    hold(4'hF, 6); hold(4'b0010, 2);
    active = 1'b1; hold(4'b0010, 1); active = 1'b0;
    hold(4'b0010, 3); hold(4'hF, 3); hold(4'b0010, 4); hold(4'hF, 4); hold(4'b0010, 5);

    // Overrun, clear coinciding with fire, ack coinciding with fire
    repeat (2) begin hold(4'hF, 5); hold(4'h0, 5); end
    hold(4'hF, 5); hold(4'h0, 4); oclr = 4'hF; hold(4'h0, 1); oclr = 4'h0; hold(4'h0, 1);
    hold(4'hF, 5); hold(4'h0, 4); ack = 4'hF; hold(4'h0, 1); ack = 4'h0; hold(4'h0, 1);
    hold(4'hF, 5); ack = 4'hF; tick(); ack = 4'h0; oclr = 4'hF; tick(); oclr = 4'h0;

    // Randomised run lengths and control noise
    limit = 24'd37;
    for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 7);
    for (int n = 0; n < 900; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin sdi[i] = ~sdi[i]; rem[i] = $urandom_range(1, 7); end
        else rem[i]--;
        cs[i]   = ($urandom_range(0, 99) < 3);
        ack[i]  = ($urandom_range(0, 3) == 0);
        oclr[i] = ($urandom_range(0, 7) == 0);
      end
      active = ($urandom_range(0, 99) < 3);
      tclr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) en = 4'($urandom_range(0, 15));
      tick();
    end

    // Watchdog expiry, clear, and a fire just before the limit
    cs = 4'h0; active = 1'b0; ack = 4'h0; oclr = 4'h0; tclr = 1'b0; en = 4'hF;
    limit = 24'd0; hold(4'hF, 2);
    limit = 24'd100; hold(4'hF, 110);
    tclr = 1'b1; tick(); tclr = 1'b0;
    limit = 24'd0; tick(); limit = 24'd100;
    hold(4'hF, 93); hold(4'h0, 6); hold(4'hF, 30);

    // Asynchronous reset mid-cycle clears everything before any edge
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1; check_all();
    rst_n = 1'b1;
    hold(4'hF, 5); hold(4'h0, 6); hold(4'hF, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
